// File: rtl/phase_pkg.sv
// phase_pkg: dual-rail codes, scheduler states and ring size shared by the phase scheduler
package phase_pkg;

   localparam logic [1:0] DR_NULL = 2'b00;
   localparam logic [1:0] DR_0    = 2'b01;
   localparam logic [1:0] DR_1    = 2'b10;
   localparam logic [1:0] DR_ERR  = 2'b11;

   localparam int NUM_PH = 3;

   typedef enum logic [2:0] {
      WAIT_VALID,
      START,
      RUN,
      ACK_HI,
      WAIT_NULL,
      ERROR
   } sched_state_t;

   function automatic logic dr_valid(input logic [1:0] code);
      return code == DR_0 || code == DR_1;
   endfunction

endpackage

// File: rtl/phase_sched_dr_sync.sv
// dr_sync: multi-flop synchroniser for one dual-rail phase code, clears to NULL on reset
module dr_sync
   import phase_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] d_i,
   output logic [1:0] q_o
);

   logic [1:0] sync_q [SYNC_STAGES];

   // shift the asynchronous code through the chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= DR_NULL;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/phase_sched.sv
// phase_sched: clocked scheduler for the 3-phase dual-rail ring; optional PHASE_SCHED_STATS_EN adds hs_count/last_lat
module phase_sched
   import phase_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_W   = 10,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           ph0,
   input  logic [1:0]           ph1,
   input  logic [1:0]           ph2,
   output logic                 ack,
   input  logic                 enable,
   output logic [NUM_PH-1:0]    stage_start,
   output logic                 stage_val,
   input  logic [NUM_PH-1:0]    stage_done,
   output logic                 busy,
   output logic                 err_order,
   output logic                 err_invalid,
   output logic                 err_timeout,
   input  logic                 clr_err
`ifdef PHASE_SCHED_STATS_EN
   ,
   output logic [15:0]          hs_count,
   output logic [TIMEOUT_W-1:0] last_lat
`endif
);

   logic [1:0]           sync_w [NUM_PH];
   logic [1:0]           code_q [NUM_PH];
   logic [NUM_PH-1:0]    vld;
   logic [1:0]           vidx;
   logic                 bad, all_null, wd_exp, set_o, set_t, set_i;
   sched_state_t         state_q, state_d;
   logic [1:0]           idx_q, idx_d, exp_q, exp_d;
   logic                 val_q, val_d, ack_q, ack_d;
   logic                 eo_q, eo_d, ei_q, ei_d, et_q, et_d;
   logic [TIMEOUT_W-1:0] wd_q, wd_d;

   dr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (.clk(clk), .rst_n(rst_n), .d_i(ph0), .q_o(sync_w[0]));
   dr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (.clk(clk), .rst_n(rst_n), .d_i(ph1), .q_o(sync_w[1]));
   dr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync2 (.clk(clk), .rst_n(rst_n), .d_i(ph2), .q_o(sync_w[2]));

   // one register after the synchronisers so the decoder sees a settled code
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PH; i++) code_q[i] <= DR_NULL;
      end else begin
         for (int i = 0; i < NUM_PH; i++) code_q[i] <= sync_w[i];
      end
   end

   // decode which phases carry data, illegal combinations and the all-NULL spacer
   always_comb begin
      vld      = '0;
      bad      = 1'b0;
      all_null = 1'b1;
      for (int i = 0; i < NUM_PH; i++) begin
         vld[i]   = dr_valid(code_q[i]);
         bad      = bad | (code_q[i] == DR_ERR);
         all_null = all_null & (code_q[i] == DR_NULL);
      end
      bad  = bad | ($countones(vld) > 1);
      vidx = vld[2] ? 2'd2 : vld[1] ? 2'd1 : 2'd0;
   end

   assign wd_exp = (state_q == RUN || state_q == WAIT_NULL) && wd_q == TIMEOUT_W'(TIMEOUT_CYC - 1);
   assign set_i  = bad;
   assign set_t  = !bad && wd_exp;
   assign set_o  = !bad && state_q == WAIT_VALID && enable && vld != '0 && vidx != exp_q;

   // next state, watchdog and sticky flags; an error of any kind overrides the normal path
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      exp_d   = exp_q;
      val_d   = val_q;
      wd_d    = wd_q;
      case (state_q)
         WAIT_VALID: if (enable && vld != '0 && vidx == exp_q) begin
            idx_d   = vidx;
            val_d   = code_q[vidx][1];
            state_d = START;
         end
         START: begin
            wd_d    = '0;
            state_d = RUN;
         end
         RUN: begin
            wd_d    = wd_q + 1'b1;
            state_d = stage_done[idx_q] ? ACK_HI : RUN;
         end
         ACK_HI: state_d = WAIT_NULL;
         WAIT_NULL: begin
            wd_d = wd_q + 1'b1;
            if (all_null) begin
               exp_d   = (exp_q == 2'd2) ? 2'd0 : exp_q + 2'd1;
               state_d = WAIT_VALID;
            end
         end
         ERROR: if (clr_err) begin
            exp_d   = '0;
            state_d = WAIT_VALID;
         end
         default: state_d = ERROR;
      endcase
      if (set_i || set_t || set_o) state_d = ERROR;
      ack_d = state_d == ACK_HI || state_d == WAIT_NULL;
      eo_d  = (eo_q & ~clr_err) | set_o;
      ei_d  = (ei_q & ~clr_err) | set_i;
      et_d  = (et_q & ~clr_err) | set_t;
   end

   // scheduler state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT_VALID;
         idx_q   <= '0;
         exp_q   <= '0;
         val_q   <= 1'b0;
         wd_q    <= '0;
         ack_q   <= 1'b0;
         eo_q    <= 1'b0;
         ei_q    <= 1'b0;
         et_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         exp_q   <= exp_d;
         val_q   <= val_d;
         wd_q    <= wd_d;
         ack_q   <= ack_d;
         eo_q    <= eo_d;
         ei_q    <= ei_d;
         et_q    <= et_d;
      end
   end

   assign stage_start = (state_q == START) ? {{(NUM_PH-1){1'b0}}, 1'b1} << idx_q : '0;
   assign stage_val   = val_q;
   assign busy        = !(state_q == WAIT_VALID || state_q == ERROR);
   assign ack         = ack_q;
   assign err_order   = eo_q;
   assign err_invalid = ei_q;
   assign err_timeout = et_q;

`ifdef PHASE_SCHED_STATS_EN
   logic [15:0]          hs_q;
   logic [TIMEOUT_W-1:0] lat_q;

   // count ack falls and capture start-to-ack latency (watchdog is 0 on the first RUN cycle)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_q  <= '0;
         lat_q <= '0;
      end else begin
         if (ack_q && !ack_d) hs_q <= hs_q + 16'd1;
         if (state_q == RUN && state_d == ACK_HI) lat_q <= wd_q + TIMEOUT_W'(2);
      end
   end

   assign hs_count = hs_q;
   assign last_lat = lat_q;
`endif

endmodule

// File: tb/tb_phase_sched.sv
// tb_phase_sched: random and directed handshakes checked against a protocol-level model
module tb_phase_sched;

   localparam int SS = 2;
   localparam int TW = 10;
   localparam int TC = 1000;
   localparam int M_IDLE = 0, M_START = 1, M_RUN = 2, M_ACK = 3, M_NULL = 4, M_ERR = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b1;
   logic          clr_err = 1'b0;
   logic [1:0]    ph [3];
   logic [2:0]    stage_done = 3'd0;
   logic          ack, stage_val, busy, err_order, err_invalid, err_timeout;
   logic [2:0]    stage_start;
`ifdef PHASE_SCHED_STATS_EN
   logic [15:0]   hs_count;
   logic [TW-1:0] last_lat;
`endif

   int errs = 0;
   int checks = 0;

   phase_sched #(.SYNC_STAGES(SS), .TIMEOUT_W(TW), .TIMEOUT_CYC(TC)) dut (
      .clk(clk), .rst_n(rst_n), .ph0(ph[0]), .ph1(ph[1]), .ph2(ph[2]),
      .ack(ack), .enable(enable), .stage_start(stage_start), .stage_val(stage_val),
      .stage_done(stage_done), .busy(busy), .err_order(err_order),
      .err_invalid(err_invalid), .err_timeout(err_timeout), .clr_err(clr_err)
`ifdef PHASE_SCHED_STATS_EN
      , .hs_count(hs_count), .last_lat(last_lat)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // protocol model: codes reach the decision 3 edges after capture
   int         m, m_exp, m_idx, m_cnt, hs_m;
   logic       m_val, m_eo, m_ei, m_et;
   logic [1:0] pipe [3][SS+1];
   logic [1:0] s [3];
   int         nv, vi, nm;
   logic       bad, nul, to, ord;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m = M_IDLE; m_exp = 0; m_idx = 0; m_cnt = 0; hs_m = 0;
         m_val = 0; m_eo = 0; m_ei = 0; m_et = 0;
         for (int i = 0; i < 3; i++) for (int j = 0; j <= SS; j++) pipe[i][j] = 2'b00;
      end else begin
         nv = 0; vi = 0; bad = 0; nul = 1; to = 0; ord = 0;
         for (int i = 0; i < 3; i++) begin
            s[i] = pipe[i][SS];
            for (int j = SS; j > 0; j--) pipe[i][j] = pipe[i][j-1];
            pipe[i][0] = ph[i];
            if (s[i] == 2'b01 || s[i] == 2'b10) begin nv++; vi = i; end
            if (s[i] == 2'b11) bad = 1;
            if (s[i] != 2'b00) nul = 0;
         end
         if (nv > 1) bad = 1;
         nm = m;
         if (m == M_RUN || m == M_NULL) begin
            m_cnt++;
            to = (m_cnt == TC);
         end
         if (m == M_IDLE && enable && nv == 1) begin
            if (vi == m_exp) begin nm = M_START; m_idx = vi; m_val = s[vi][1]; end
            else ord = 1;
         end
         else if (m == M_START) begin m_cnt = 0; nm = M_RUN; end
         else if (m == M_RUN && stage_done[m_idx]) nm = M_ACK;
         else if (m == M_ACK) nm = M_NULL;
         else if (m == M_NULL && nul) begin nm = M_IDLE; m_exp = (m_exp + 1) % 3; end
         else if (m == M_ERR && clr_err) begin nm = M_IDLE; m_exp = 0; end
         if (clr_err) begin m_eo = 0; m_ei = 0; m_et = 0; end
         if (bad) begin m_ei = 1; nm = M_ERR; end
         else if (to) begin m_et = 1; nm = M_ERR; end
         else if (ord) begin m_eo = 1; nm = M_ERR; end
         if ((m == M_ACK || m == M_NULL) && !(nm == M_ACK || nm == M_NULL)) hs_m++;
         m = nm;
      end
   end

   int cyc = 0;
   int start_cyc = 0;

   // compare every cycle outside reset
   always @(negedge clk) begin
      if (rst_n) begin
         cyc++;
         chk("ack", 16'(ack), 16'(m == M_ACK || m == M_NULL));
         chk("stage_start", 16'(stage_start), (m == M_START) ? 16'(1 << m_idx) : 16'd0);
         chk("busy", 16'(busy), 16'(m >= M_START && m <= M_NULL));
         if (m >= M_START && m <= M_NULL) chk("stage_val", 16'(stage_val), 16'(m_val));
         chk("err_order", 16'(err_order), 16'(m_eo));
         chk("err_invalid", 16'(err_invalid), 16'(m_ei));
         chk("err_timeout", 16'(err_timeout), 16'(m_et));
`ifdef PHASE_SCHED_STATS_EN
         if (m == M_START) start_cyc = cyc;
         if (m == M_ACK) chk("last_lat", 16'(last_lat), 16'(cyc - start_cyc));
         chk("hs_count", hs_count, 16'(hs_m));
`endif
      end
   end

   task automatic wait_start(input int k, input logic v);
      int n = 0;
      while (stage_start == 3'd0 && n < 40) begin @(negedge clk); n++; end
      chk("start_onehot", 16'(stage_start), 16'(1 << k));
      chk("start_val", 16'(stage_val), 16'(v));
   endtask

   task automatic wait_ack(input logic lvl);
      int n = 0;
      while (ack !== lvl && n < 40) begin @(negedge clk); n++; end
      chk(lvl ? "ack_rise" : "ack_fall", 16'(ack), 16'(lvl));
   endtask

   task automatic hs_body(input int k, input logic v, input int dly);
      wait_start(k, v);
      enable = ($urandom_range(0, 3) != 0);
      repeat (dly + 1) @(negedge clk);
      stage_done[k] = 1'b1;
      if ($urandom_range(0, 1) == 1) begin @(negedge clk); stage_done[k] = 1'b0; end
      wait_ack(1'b1);
      @(negedge clk);
      ph[k] = 2'b00;
      wait_ack(1'b0);
      stage_done = 3'd0;
      enable = 1'b1;
   endtask

   task automatic hs(input int k, input logic v, input int dly);
      ph[k] = v ? 2'b10 : 2'b01;
      hs_body(k, v, dly);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) ph[i] = 2'b00;
      stage_done = 3'd0; clr_err = 1'b0; enable = 1'b1;
      @(negedge clk); rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic clear_err();
      for (int i = 0; i < 3; i++) ph[i] = 2'b00;
      stage_done = 3'd0;
      repeat (6) @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      @(negedge clk);
      chk("clr_flags", {13'd0, err_order, err_invalid, err_timeout}, 16'd0);
      chk("clr_busy", 16'(busy), 16'd0);
   endtask

   initial begin
      int n, cnt, e, w;
      logic seen;
      for (int i = 0; i < 3; i++) ph[i] = 2'b00;
      #12;
      chk("rst_ack", 16'(ack), 16'd0);
      chk("rst_start", 16'(stage_start), 16'd0);
      chk("rst_val", 16'(stage_val), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_errs", {13'd0, err_order, err_invalid, err_timeout}, 16'd0);
      @(negedge clk); rst_n = 1'b1;

      // full ring: values 1,0,0 then wrap to PH0
      hs(0, 1'b1, 2);
      hs(1, 1'b0, 0);
      hs(2, 1'b0, 3);
`ifdef PHASE_SCHED_STATS_EN
      chk("hs_count_3", hs_count, 16'd3);
`endif
      hs(0, 1'b0, 1);

      // out-of-order token after reset
      do_reset();
      ph[1] = 2'b01;
      n = 0;
      while (!err_order && n < 15) begin @(negedge clk); n++; end
      chk("order_err", 16'(err_order), 16'd1);
      chk("order_ack", 16'(ack), 16'd0);
      chk("order_busy", 16'(busy), 16'd0);
      clear_err();

      // illegal code during RUN
      ph[0] = 2'b10;
      wait_start(0, 1'b1);
      @(negedge clk);
      ph[2] = 2'b11;
      n = 0;
      while (!err_invalid && n < 15) begin @(negedge clk); n++; end
      chk("invalid_11", 16'(err_invalid), 16'd1);
      cnt = 0;
      repeat (20) begin @(negedge clk); if (stage_start != 3'd0) cnt++; end
      chk("no_start_in_error", 16'(cnt), 16'd0);
      clear_err();

      // two phases valid together
      ph[0] = 2'b10; ph[1] = 2'b01;
      n = 0;
      while (!err_invalid && n < 15) begin @(negedge clk); n++; end
      chk("invalid_multi", 16'(err_invalid), 16'd1);
      chk("invalid_not_order", 16'(err_order), 16'd0);
      clear_err();

      // watchdog, with a foreign done bit that must be ignored
      ph[0] = 2'b01;
      wait_start(0, 1'b0);
      stage_done = 3'b010;
      n = 0; seen = 1'b0;
      while (!err_timeout && n < 1100) begin @(negedge clk); n++; seen |= ack; end
      chk("timeout_cycles", 16'(n), 16'd1001);
      chk("foreign_done_no_ack", 16'(seen), 16'd0);
      clear_err();

      // async reset while ack is high
      ph[0] = 2'b10;
      wait_start(0, 1'b1);
      @(negedge clk);
      stage_done[0] = 1'b1;
      wait_ack(1'b1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_ack", 16'(ack), 16'd0);
      chk("async_rst_busy", 16'(busy), 16'd0);
      for (int i = 0; i < 3; i++) ph[i] = 2'b00;
      stage_done = 3'd0;
      @(negedge clk);
      @(negedge clk); rst_n = 1'b1;

      // enable low blocks new tokens
      enable = 1'b0;
      ph[0] = 2'b01;
      cnt = 0;
      repeat (15) begin @(negedge clk); if (stage_start != 3'd0) cnt++; end
      chk("enable_block", 16'(cnt), 16'd0);
      enable = 1'b1;
      hs_body(0, 1'b0, 1);

      // random ring traffic with occasional out-of-order tokens
      do_reset();
      e = 0;
      repeat (40) begin
         if ($urandom_range(0, 9) == 0) begin
            w = (e + 1 + $urandom_range(0, 1)) % 3;
            ph[w] = 2'b01;
            repeat (8) @(negedge clk);
            clear_err();
            e = 0;
         end else begin
            hs(e, 1'($urandom_range(0, 1)), $urandom_range(0, 6));
            e = (e + 1) % 3;
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
